// File: rtl/jtag_master.sv
// JTAG master: shifts up to 32 TMS/TDI bits per command while capturing TDO,
// and can pulse TRSTN. Commands and responses use valid/ready handshakes.
module jtag_master #(
    parameter int DIV      = 2,
    parameter int TRST_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_tms,
    input  logic [31:0] cmd_tdi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    output logic        trstn,
    input  logic        tdo
);

    localparam int CNT_MAX = (DIV > TRST_CYC) ? DIV : TRST_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] TRST_LAST = CW'(TRST_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        TRST,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    idx;
    logic [4:0]    idx_next;
    logic [4:0]    len_r;
    logic [31:0]   tms_r;
    logic [31:0]   tdi_r;
    logic          load;

    assign idx_next = idx + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            len_r     <= '0;
            tms_r     <= '0;
            tdi_r     <= '0;
            load      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            trstn     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            2'b00: begin
                                // Pins are driven one cycle later so bit 0 gets a full low phase.
                                state    <= LOW;
                                load     <= 1'b1;
                                cnt      <= '0;
                                idx      <= '0;
                                len_r    <= cmd_len;
                                tms_r    <= cmd_tms;
                                tdi_r    <= cmd_tdi;
                                rsp_data <= '0;
                                rsp_err  <= 1'b0;
                            end
                            2'b01: begin
                                state    <= TRST;
                                cnt      <= '0;
                                trstn    <= 1'b0;
                                tck      <= 1'b0;
                                tms      <= 1'b1;
                                rsp_data <= '0;
                                rsp_err  <= 1'b0;
                            end
                            default: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                            end
                        endcase
                    end
                end
                LOW: begin
                    if (load) begin
                        load <= 1'b0;
                        tms  <= tms_r[idx];
                        tdi  <= tdi_r[idx];
                        cnt  <= '0;
                    end else if (cnt == DIV_LAST) begin
                        // TDO is captured on the same edge that raises TCK.
                        tck           <= 1'b1;
                        rsp_data[idx] <= tdo;
                        cnt           <= '0;
                        state         <= HIGH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (cnt == DIV_LAST) begin
                        tck <= 1'b0;
                        cnt <= '0;
                        if (idx == len_r) begin
                            // TMS keeps the last bit so the TAP parks in a stable state.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            tdi       <= 1'b0;
                        end else begin
                            idx   <= idx_next;
                            tms   <= tms_r[idx_next];
                            tdi   <= tdi_r[idx_next];
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TRST: begin
                    if (cnt == TRST_LAST) begin
                        trstn     <= 1'b1;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Scoreboard bench for jtag_master: a DIV=2 instance with a TDI->TDO loopback target
// and a DIV=1 instance with TDO tied high receive the same command stream.
module tb_jtag_master;

    localparam int TRST_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        rsp_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        cmd_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_data  [2];
    logic        tck       [2];
    logic        tms       [2];
    logic        tdi       [2];
    logic        trstn     [2];
    logic        tdo       [2];

    int   vectors     = 0;
    int   miscompares = 0;
    logic hold_ready  = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          rises;
        int          trst_low;
        logic        is_shift;
        logic        tms_last;
    } exp_t;

    exp_t exp_q [2][$];

    always #5 clk = ~clk;

    // Target for instance 0 returns the TDI value seen at the previous TCK fall.
    logic lb_tck = 1'b0;
    logic lb_tdi = 1'b0;
    logic lb_tdo = 1'b0;
    always @(negedge clk) begin
        if (lb_tck && !tck[0]) lb_tdo <= lb_tdi;
        lb_tck <= tck[0];
        lb_tdi <= tdi[0];
    end
    assign tdo[0] = lb_tdo;
    assign tdo[1] = 1'b1;

    function automatic void check(input string name, input int g, input logic [63:0] act,
                                  input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s u%0d: actual 0x%0h, required 0x%0h", name, g, act, req);
        end
    endfunction

    function automatic exp_t model(input int g, input logic [1:0] op, input logic [4:0] len,
                                   input logic [31:0] t_ms, input logic [31:0] t_di,
                                   input logic tdo_now);
        exp_t        e;
        int          div;
        int          n;
        logic [63:0] mask;
        logic [63:0] shifted;
        div        = (g == 0) ? 2 : 1;
        n          = int'(len) + 1;
        mask       = (64'd1 << n) - 64'd1;
        shifted    = ({32'd0, t_di} << 1) | {63'd0, tdo_now};
        e.data     = '0;
        e.err      = 1'b0;
        e.lat      = 0;
        e.rises    = 0;
        e.trst_low = 0;
        e.is_shift = 1'b0;
        e.tms_last = 1'b0;
        if (op == 2'b00) begin
            e.data     = (g == 0) ? (shifted[31:0] & mask[31:0]) : mask[31:0];
            e.lat      = 1 + 2 * div * n;
            e.rises    = n;
            e.is_shift = 1'b1;
            e.tms_last = t_ms[len];
        end else if (op == 2'b01) begin
            e.lat      = TRST_CYC;
            e.trst_low = TRST_CYC;
        end else begin
            e.err = 1'b1;
            e.lat = 0;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 2 : 1;

        jtag_master #(.DIV(D), .TRST_CYC(TRST_CYC)) dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready[g]),
            .cmd_op    (cmd_op),
            .cmd_len   (cmd_len),
            .cmd_tms   (cmd_tms),
            .cmd_tdi   (cmd_tdi),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .tck       (tck[g]),
            .tms       (tms[g]),
            .tdi       (tdi[g]),
            .trstn     (trstn[g]),
            .tdo       (tdo[g])
        );

        int          lat       = 0;
        int          rises     = 0;
        int          trst_low  = 0;
        int          hi_run    = 0;
        int          lo_run    = 1000;
        int          pulse_bad = 0;
        int          hold_bad  = 0;
        logic        busy      = 1'b0;
        logic        got       = 1'b0;
        logic        prev_tck  = 1'b0;
        logic [31:0] data_at   = '0;
        logic        err_at    = 1'b0;
        logic        tms_at    = 1'b0;
        logic        tdi_at    = 1'b0;
        exp_t        e;

        // Monitor: measures pin activity per command and scores each response at its handshake.
        always @(negedge clk) begin
            if (tck[g] && !prev_tck) begin
                if (busy) begin
                    rises++;
                    if (lo_run < D) pulse_bad++;
                end
                hi_run = 1;
            end else if (!tck[g] && prev_tck) begin
                if (busy && hi_run != D) pulse_bad++;
                lo_run = 1;
            end else if (tck[g]) begin
                hi_run++;
            end else begin
                lo_run++;
            end
            prev_tck = tck[g];

            if (rst) begin
                busy = 1'b0;
                got  = 1'b0;
            end else begin
                if (busy) begin
                    if (!trstn[g]) trst_low++;
                    if (!got) begin
                        lat++;
                        if (rsp_valid[g]) begin
                            got     = 1'b1;
                            data_at = rsp_data[g];
                            err_at  = rsp_err[g];
                            tms_at  = tms[g];
                            tdi_at  = tdi[g];
                        end
                    end
                    if (got) begin
                        if (!rsp_valid[g] || rsp_data[g] !== data_at || rsp_err[g] !== err_at ||
                            cmd_ready[g] !== 1'b0)
                            hold_bad++;
                        if (rsp_ready) begin
                            if (exp_q[g].size() == 0) begin
                                vectors++;
                                miscompares++;
                                $display("[TB] FAIL unexpected_rsp u%0d: actual data 0x%0h, required no response",
                                         g, rsp_data[g]);
                            end else begin
                                e = exp_q[g].pop_front();
                                check("rsp_data", g, data_at, e.data);
                                check("rsp_err", g, err_at, e.err);
                                check("latency", g, lat, e.lat);
                                check("tck_pulses", g, rises, e.rises);
                                check("trstn_low_cycles", g, trst_low, e.trst_low);
                                check("tck_width_errors", g, pulse_bad, 0);
                                check("rsp_hold_errors", g, hold_bad, 0);
                                if (e.is_shift) begin
                                    check("tms_after_shift", g, tms_at, e.tms_last);
                                    check("tdi_after_shift", g, tdi_at, 0);
                                end
                            end
                            busy = 1'b0;
                            got  = 1'b0;
                        end
                    end
                end else if (rsp_valid[g]) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL spurious_rsp_valid u%0d: actual 1, required 0", g);
                end
                if (cmd_valid && cmd_ready[g]) begin
                    busy      = 1'b1;
                    got       = 1'b0;
                    lat       = -1;
                    rises     = 0;
                    trst_low  = 0;
                    pulse_bad = 0;
                    hold_bad  = 0;
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] len,
                                 input logic [31:0] t_ms, input logic [31:0] t_di);
        int waited = 0;
        @(negedge clk);
        while (!(cmd_ready[0] && cmd_ready[1]) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!(cmd_ready[0] && cmd_ready[1])) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL cmd_ready_timeout: actual %0b%0b, required 11", cmd_ready[1], cmd_ready[0]);
            return;
        end
        @(posedge clk);
        #1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_tms   = t_ms;
        cmd_tdi   = t_di;
        cmd_valid = 1'b1;
        for (int g = 0; g < 2; g++) exp_q[g].push_back(model(g, op, len, t_ms, t_di, lb_tdo));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = 5'($urandom);
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
    endtask

    task automatic checkOutput();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rsp_timeout: actual %0d/%0d pending, required 0", exp_q[0].size(), exp_q[1].size());
            exp_q[0].delete();
            exp_q[1].delete();
        end
    endtask

    initial begin
        logic [1:0] op;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_tck", g, tck[g], 0);
            check("reset_tms", g, tms[g], 1);
            check("reset_tdi", g, tdi[g], 0);
            check("reset_trstn", g, trstn[g], 1);
            check("reset_cmd_ready", g, cmd_ready[g], 0);
            check("reset_rsp_valid", g, rsp_valid[g], 0);
            check("reset_rsp_err", g, rsp_err[g], 0);
            check("reset_rsp_data", g, rsp_data[g], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) check("ready_after_reset", g, cmd_ready[g], 1);

        applyStimulus(2'b00, 5'd7, 32'h0000_0000, 32'h0000_00A5);
        checkOutput();
        applyStimulus(2'b00, 5'd4, 32'h0000_001F, 32'h0000_0000);
        checkOutput();
        applyStimulus(2'b01, 5'd0, 32'h0, 32'h0);
        checkOutput();

        @(negedge clk);
        hold_ready = 1'b1;
        applyStimulus(2'b11, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("held_rsp_valid", g, rsp_valid[g], 1);
            check("held_cmd_ready", g, cmd_ready[g], 0);
            check("held_rsp_err", g, rsp_err[g], 1);
        end
        hold_ready = 1'b0;
        checkOutput();

        applyStimulus(2'b00, 5'd31, $urandom, $urandom);
        checkOutput();

        // Reset lands during bit 3 of a 32-bit shift on the DIV=2 instance.
        applyStimulus(2'b00, 5'd31, $urandom, $urandom);
        repeat (13) @(posedge clk);
        #1 rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("midshift_rst_tck", g, tck[g], 0);
            check("midshift_rst_tms", g, tms[g], 1);
            check("midshift_rst_rsp_valid", g, rsp_valid[g], 0);
            check("midshift_rst_cmd_ready", g, cmd_ready[g], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) check("ready_after_midshift_rst", g, cmd_ready[g], 1);
        applyStimulus(2'b00, 5'd0, $urandom, $urandom);
        checkOutput();

        repeat (25) begin
            if ($urandom_range(0, 9) < 7) op = 2'b00;
            else if ($urandom_range(0, 1) == 1) op = 2'b01;
            else op = 2'($urandom_range(2, 3));
            applyStimulus(op, 5'($urandom), $urandom, $urandom);
            checkOutput();
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
